// File: rtl/mac_dot_accum.sv
// mac_dot_accum: N-lane dot-product multiply-accumulate with three advance-gated
// pipeline stages (products, adder tree, accumulate/output) and a valid/ready
// result port that applies backpressure all the way to the operand input.
module mac_dot_accum #(
  parameter int LANES    = 4,
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 32,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ivalid,
  output logic                      oready,
  input  logic [LANES*DATA_W-1:0]   dataa,
  input  logic [LANES*DATA_W-1:0]   datab,
  input  logic                      ilast,
  output logic                      ovalid,
  input  logic                      iready,
  output logic [ACC_W-1:0]          result,
  output logic                      osat
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = PROD_W + $clog2(LANES);
  // Wide enough for the accumulator plus one growth bit even if the tree sum
  // is wider than the accumulator.
  localparam int EXT_W  = ((SUM_W > ACC_W) ? SUM_W : ACC_W) + 1;

  logic                          advance;
  logic [LANES-1:0][PROD_W-1:0]  prod_next;
  logic [LANES-1:0][PROD_W-1:0]  prod_reg;
  logic [LANES-1:0][SUM_W-1:0]   prod_ext;
  logic                          s1_valid_reg, s1_last_reg;
  logic [SUM_W-1:0]              sum_next, sum_reg;
  logic                          s2_valid_reg, s2_last_reg;
  logic [ACC_W-1:0]              acc_reg;
  logic                          sticky_reg, first_reg;
  logic                          sum_sgn, acc_sgn;
  logic [EXT_W-1:0]              sum_ext, base_ext, acc_wide;
  logic [EXT_W-ACC_W:0]          hi_bits;
  logic                          ovf;
  logic [ACC_W-1:0]              clamp_val, acc_next;
  logic                          sticky_next;

  // The whole pipeline moves only when the output slot is free or being drained.
  assign advance = !ovalid | iready;
  assign oready  = advance;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic              ext_a, ext_b, ext_p;
    logic [PROD_W-1:0] op_a, op_b;
    // Extend operands to product width so the truncated product is exact.
    assign ext_a = (SIGNED != 0) ? dataa[gi*DATA_W + DATA_W - 1] : 1'b0;
    assign ext_b = (SIGNED != 0) ? datab[gi*DATA_W + DATA_W - 1] : 1'b0;
    assign op_a  = {{DATA_W{ext_a}}, dataa[gi*DATA_W +: DATA_W]};
    assign op_b  = {{DATA_W{ext_b}}, datab[gi*DATA_W +: DATA_W]};
    assign prod_next[gi] = op_a * op_b;
    // Registered product extended to tree width (a no-op when LANES == 1).
    assign ext_p = (SIGNED != 0) ? prod_reg[gi][PROD_W-1] : 1'b0;
    assign prod_ext[gi] = SUM_W'($signed({ext_p, prod_reg[gi]}));
  end

  // Adder tree over all lanes; collapses to a plain wire for a single lane.
  always_comb begin
    sum_next = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_next = sum_next + prod_ext[i];
    end
  end

  // Accumulate at extended width, then detect and handle overflow.
  assign sum_sgn  = (SIGNED != 0) ? sum_reg[SUM_W-1] : 1'b0;
  assign acc_sgn  = (SIGNED != 0) ? acc_reg[ACC_W-1] : 1'b0;
  assign sum_ext  = EXT_W'($signed({sum_sgn, sum_reg}));
  assign base_ext = first_reg ? '0 : EXT_W'($signed({acc_sgn, acc_reg}));
  assign acc_wide = base_ext + sum_ext;
  assign hi_bits  = acc_wide[EXT_W-1:ACC_W-1];
  assign ovf      = (SIGNED != 0) ? !((&hi_bits) | ~(|hi_bits))
                                  : (|acc_wide[EXT_W-1:ACC_W]);
  assign clamp_val = (SIGNED == 0)        ? {ACC_W{1'b1}} :
                     acc_wide[EXT_W-1]    ? {1'b1, {(ACC_W-1){1'b0}}} :
                                            {1'b0, {(ACC_W-1){1'b1}}};
  assign acc_next    = (ovf && (SATURATE != 0)) ? clamp_val : acc_wide[ACC_W-1:0];
  assign sticky_next = (first_reg ? 1'b0 : sticky_reg) | ovf;

  // Stage 1: per-lane products and the end-of-vector flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
      prod_reg     <= '0;
    end else if (advance) begin
      s1_valid_reg <= ivalid;
      s1_last_reg  <= ilast;
      prod_reg     <= prod_next;
    end
  end

  // Stage 2: registered adder-tree sum.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s2_valid_reg <= 1'b0;
      s2_last_reg  <= 1'b0;
      sum_reg      <= '0;
    end else if (advance) begin
      s2_valid_reg <= s1_valid_reg;
      s2_last_reg  <= s1_last_reg;
      sum_reg      <= sum_next;
    end
  end

  // Stage 3: accumulate; a last beat publishes the result and rearms the vector.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_reg    <= '0;
      sticky_reg <= 1'b0;
      first_reg  <= 1'b1;
      result     <= '0;
      osat       <= 1'b0;
      ovalid     <= 1'b0;
    end else if (advance) begin
      if (s2_valid_reg) begin
        acc_reg    <= acc_next;
        sticky_reg <= sticky_next;
        first_reg  <= s2_last_reg;
        if (s2_last_reg) begin
          result <= acc_next;
          osat   <= sticky_next;
          ovalid <= 1'b1;
        end else begin
          ovalid <= 1'b0;
        end
      end else begin
        ovalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_dot_accum.sv
// tb_mac_dot_accum: drives four parameterisations of mac_dot_accum with shared
// stimulus; an integer reference model queues expected results per vector and a
// monitor pops and compares them as each result is handed off downstream.
module tb_mac_dot_accum;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ivalid = 1'b0;
  logic        ilast = 1'b0;
  logic        iready = 1'b1;
  logic [31:0] dataa = '0;
  logic [31:0] datab = '0;

  logic [31:0] r0, r3;
  logic [15:0] r1, r2;
  logic [3:0]  ov_mon, os_mon, rdy_mon;
  logic [31:0] res_mon [4];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc = 0;

  typedef struct packed {
    logic [3:0][31:0] res;
    logic [3:0]       sat;
  } exp_t;
  exp_t exp_q[$];

  // Configurations: 0 default, 1 16-bit saturating, 2 16-bit wrapping, 3 unsigned
  int cfg_w   [4] = '{32, 16, 16, 32};
  bit cfg_s   [4] = '{1, 1, 1, 0};
  bit cfg_sat [4] = '{1, 1, 0, 1};
  longint m_acc [4];
  bit m_sticky [4];
  bit m_first [4] = '{1, 1, 1, 1};

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  mac_dot_accum u0 (.clock(clock), .reset(reset), .ivalid(ivalid), .oready(rdy_mon[0]),
    .dataa(dataa), .datab(datab), .ilast(ilast), .ovalid(ov_mon[0]), .iready(iready),
    .result(r0), .osat(os_mon[0]));
  mac_dot_accum #(.ACC_W(16), .SATURATE(1)) u1 (.clock(clock), .reset(reset), .ivalid(ivalid),
    .oready(rdy_mon[1]), .dataa(dataa), .datab(datab), .ilast(ilast), .ovalid(ov_mon[1]),
    .iready(iready), .result(r1), .osat(os_mon[1]));
  mac_dot_accum #(.ACC_W(16), .SATURATE(0)) u2 (.clock(clock), .reset(reset), .ivalid(ivalid),
    .oready(rdy_mon[2]), .dataa(dataa), .datab(datab), .ilast(ilast), .ovalid(ov_mon[2]),
    .iready(iready), .result(r2), .osat(os_mon[2]));
  mac_dot_accum #(.SIGNED(0)) u3 (.clock(clock), .reset(reset), .ivalid(ivalid),
    .oready(rdy_mon[3]), .dataa(dataa), .datab(datab), .ilast(ilast), .ovalid(ov_mon[3]),
    .iready(iready), .result(r3), .osat(os_mon[3]));

  assign res_mon[0] = r0;
  assign res_mon[1] = {16'h0, r1};
  assign res_mon[2] = {16'h0, r2};
  assign res_mon[3] = r3;

  // Reference model: integer arithmetic, range check, clamp or wrap.
  function automatic void model_beat(input logic [31:0] a, input logic [31:0] b, input logic last);
    exp_t e;
    longint one = 1;
    longint s, v, lo, hi, ai, bi, base;
    bit st, ovf;
    e = '0;
    for (int k = 0; k < 4; k++) begin
      s = 0;
      for (int i = 0; i < 4; i++) begin
        ai = cfg_s[k] ? longint'($signed(a[i*8 +: 8])) : longint'(a[i*8 +: 8]);
        bi = cfg_s[k] ? longint'($signed(b[i*8 +: 8])) : longint'(b[i*8 +: 8]);
        s += ai * bi;
      end
      if (cfg_s[k]) begin
        lo = -(one << (cfg_w[k] - 1));
        hi = (one << (cfg_w[k] - 1)) - 1;
      end else begin
        lo = 0;
        hi = (one << cfg_w[k]) - 1;
      end
      base = m_first[k] ? 0 : m_acc[k];
      st   = m_first[k] ? 1'b0 : m_sticky[k];
      v    = base + s;
      ovf  = (v < lo) || (v > hi);
      if (ovf) begin
        if (cfg_sat[k]) v = (v > hi) ? hi : lo;
        else begin
          v = v & ((one << cfg_w[k]) - 1);
          if (cfg_s[k] && v > hi) v = v - (one << cfg_w[k]);
        end
      end
      m_acc[k] = v;
      m_sticky[k] = st | ovf;
      m_first[k] = last;
      e.res[k] = v[31:0];
      e.sat[k] = st | ovf;
    end
    if (last) exp_q.push_back(e);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin
      m_acc[k] = 0;
      m_sticky[k] = 1'b0;
      m_first[k] = 1'b1;
    end
  endfunction

  // Monitor: a result transfers at the next edge when ovalid & iready here.
  always @(negedge clock) begin
    if (!reset) begin
      if (ov_mon != 4'h0) begin
        n_vec++;
        if (ov_mon !== 4'hF) begin
          n_err++;
          $display("FAIL ovalid_agree: ovalid per config %b, required all equal", ov_mon);
        end
      end
      if (ov_mon[0] === 1'b1 && iready === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_result: result %0d with no vector pending", $signed(r0));
        end else begin
          exp_t e;
          logic [31:0] mask;
          e = exp_q.pop_front();
          for (int k = 0; k < 4; k++) begin
            mask = (cfg_w[k] == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
            n_vec++;
            if (res_mon[k] !== (e.res[k] & mask) || os_mon[k] !== e.sat[k]) begin
              n_err++;
              $display("FAIL result_cfg%0d: got result=%h osat=%b, expected result=%h osat=%b",
                       k, res_mon[k], os_mon[k], e.res[k] & mask, e.sat[k]);
            end
          end
          $display("cfg0 result %0d osat %b handed off at cycle %0d", $signed(r0), os_mon[0], cyc);
        end
      end
    end
  end

  // Present one beat (entered just after a rising edge) until it is accepted.
  task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic last);
    logic ok;
    dataa = a; datab = b; ilast = last; ivalid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      ok = rdy_mon[0];
      @(posedge clock);
      if (ok) break;
    end
    #1;
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL beat_accept: beat not accepted in 100 cycles, oready=%b required 1", rdy_mon[0]);
    end else begin
      model_beat(a, b, last);
      acc_cyc = cyc;
    end
    ivalid = 1'b0; ilast = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 60; c++) begin
      if (exp_q.size() == 0 && ov_mon[0] == 1'b0) break;
      @(posedge clock); #1;
    end
    n_vec++;
    if (exp_q.size() != 0 || ov_mon[0] !== 1'b0) begin
      n_err++;
      $display("FAIL drain: %0d results still pending, ovalid=%b, required 0 and 0", exp_q.size(), ov_mon[0]);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    n_vec++;
    if (ov_mon !== 4'h0 || os_mon !== 4'h0 || r0 !== 32'h0 || r1 !== 16'h0 || r3 !== 32'h0) begin
      n_err++;
      $display("FAIL reset_state: ovalid=%b osat=%b r0=%h, required all zero", ov_mon, os_mon, r0);
    end
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    n_vec++;
    if (rdy_mon !== 4'hF) begin
      n_err++;
      $display("FAIL reset_oready: oready=%b, required 1111", rdy_mon);
    end
  endtask

  task automatic test_single_beat();
    int lat;
    lat = -1;
    @(posedge clock); #1;
    send_beat({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 1'b1);
    for (int c = 0; c < 20; c++) begin
      if (ov_mon[0]) begin
        lat = cyc - acc_cyc + 1;
        break;
      end
      @(posedge clock); #1;
    end
    n_vec++;
    // Edges counted from the accepting edge through the edge that raises ovalid.
    if (lat != 3) begin
      n_err++;
      $display("FAIL latency: result after %0d edges, required 3", lat);
    end
    n_vec++;
    if (r0 !== 32'd70) begin
      n_err++;
      $display("FAIL single_beat_value: result %0d, required 70", $signed(r0));
    end
    drain();
  endtask

  task automatic test_multi_beat();
    for (int i = 0; i < 3; i++) send_beat({4{8'h80}}, {4{8'h80}}, i == 2);
    drain();
  endtask

  task automatic test_back_to_back();
    logic got;
    fork
      begin
        send_beat({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 1'b1);
        send_beat({4{8'd1}}, {4{8'd1}}, 1'b1);
        send_beat({4{8'hFF}}, {4{8'd1}}, 1'b1);
      end
      begin
        got = 1'b0;
        for (int c = 0; c < 30; c++) begin
          @(posedge clock); #1;
          if (ov_mon[0]) begin got = 1'b1; break; end
        end
        iready = 1'b0;
        n_vec++;
        if (!got) begin
          n_err++;
          $display("FAIL b2b_first: ovalid=%b, required 1 within 30 cycles", ov_mon[0]);
        end
        repeat (5) begin
          @(negedge clock);
          n_vec++;
          if (rdy_mon[0] !== 1'b0 || r0 !== 32'd70 || ov_mon[0] !== 1'b1) begin
            n_err++;
            $display("FAIL stall_hold: oready=%b result=%0d ovalid=%b, required 0 70 1",
                     rdy_mon[0], $signed(r0), ov_mon[0]);
          end
        end
        @(posedge clock); #1 iready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_overflow();
    send_beat({4{8'h80}}, {4{8'h80}}, 1'b1);
    drain();
    send_beat({4{8'd1}}, {4{8'd1}}, 1'b1);
    drain();
  endtask

  task automatic test_reset_midstream();
    send_beat({4{8'd25}}, {4{8'd40}}, 1'b0);
    send_beat({4{8'd25}}, {4{8'd40}}, 1'b0);
    reset = 1'b1;
    model_reset();
    repeat (3) begin
      @(negedge clock);
      n_vec++;
      if (ov_mon !== 4'h0) begin
        n_err++;
        $display("FAIL reset_ovalid: ovalid=%b during reset, required 0000", ov_mon);
      end
    end
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    n_vec++;
    if (rdy_mon[0] !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_oready: oready=%b, required 1", rdy_mon[0]);
    end
    @(posedge clock); #1;
    send_beat({4{8'd1}}, {4{8'd1}}, 1'b1);
    drain();
  endtask

  task automatic test_unsigned();
    send_beat({4{8'hFF}}, {4{8'hFF}}, 1'b1);
    drain();
  endtask

  task automatic test_random();
    fork
      begin
        for (int i = 0; i < 30; i++)
          send_beat($urandom, $urandom, (i == 29) || ($urandom_range(0, 2) == 0));
      end
      begin
        for (int c = 0; c < 60; c++) begin
          @(posedge clock); #1 iready = ($urandom_range(0, 3) != 0);
        end
        iready = 1'b1;
      end
    join
    iready = 1'b1;
    drain();
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_multi_beat();
    test_back_to_back();
    test_overflow();
    test_reset_midstream();
    test_unsigned();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
